// File: rtl/ballot_pkg.sv
// ballot_pkg
// Shared definitions for the voting-booth ballot controller: the controller
// state encoding, default values for the block parameters, and the width of
// the ballots-cast counter.
package ballot_pkg;

  localparam int NUM_CAND_DEF        = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int ARM_TIMEOUT_DEF     = 1000;
  localparam int TOTAL_W             = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAST,
    RELEASE
  } ballot_state_e;

endpackage

// File: rtl/ballot_debounce.sv
// ballot_debounce
// Brings the raw candidate buttons into the clock domain through a 2-flop
// synchroniser, then only publishes a new button vector once the synchronised
// value has stayed identical for STABLE_CYCLES consecutive cycles.
// Ports:
//   clk   - rising-edge clock
//   clear - synchronous active-high reset (zeroes synchroniser and counter)
//   i_raw - asynchronous active-high button vector
//   o_db  - debounced button vector
module ballot_debounce
  import ballot_pkg::*;
#(
  parameter int WIDTH         = NUM_CAND_DEF,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_db
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // cand_q is the vector currently being timed; cnt_q is how many cycles it
  // has been seen in a row. Any change restarts timing at one cycle, and the
  // counter saturates once the vector has been accepted.
  always_comb begin
    sync1_d = i_raw;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CW'(1);
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == CW'(STABLE_CYCLES)) begin
      db_d = cand_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign o_db = db_q;

endmodule

// File: rtl/vote_ballot_ctrl.sv
// vote_ballot_ctrl
// Ballot controller for one voting booth. An officer arms the booth for one
// voter; the voter's debounced single-button press is forwarded as a one-cycle
// one-hot pulse to the candidate counters, multi-button presses are rejected,
// and an armed booth that sees no vote times out back to idle.
// Ports:
//   clk        - rising-edge clock
//   clear      - synchronous active-high reset
//   i_arm      - officer authorises one voter (honoured only in IDLE)
//   i_btn      - raw asynchronous candidate buttons, active-high
//   o_vote     - one-hot single-cycle vote pulse
//   o_enable_n - active-low counter enable (high only around clear)
//   o_ready    - high while armed and waiting for a vote
//   o_reject   - single-cycle pulse on a multi-button press
//   o_timeout  - single-cycle pulse when the armed window expires
//   o_total    - saturating count of ballots cast since reset
module vote_ballot_ctrl
  import ballot_pkg::*;
#(
  parameter int NUM_CAND        = NUM_CAND_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ARM_TIMEOUT     = ARM_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                i_arm,
  input  logic [NUM_CAND-1:0] i_btn,
  output logic [NUM_CAND-1:0] o_vote,
  output logic                o_enable_n,
  output logic                o_ready,
  output logic                o_reject,
  output logic                o_timeout,
  output logic [TOTAL_W-1:0]  o_total
);

  localparam int TW = $clog2(ARM_TIMEOUT + 1);

  ballot_state_e       state_q, state_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                wait_zero_q, wait_zero_d;
  logic [NUM_CAND-1:0] vote_q, vote_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic                en_n_q, en_n_d;

  logic [NUM_CAND-1:0] db_vec;
  logic                db_zero;
  logic                db_single;
  logic                db_multi;

  ballot_debounce #(
    .WIDTH         (NUM_CAND),
    .STABLE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .clear (clear),
    .i_raw (i_btn),
    .o_db  (db_vec)
  );

  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign db_zero   = (db_vec == '0);
  assign db_single = !db_zero && ((db_vec & (db_vec - NUM_CAND'(1))) == '0);
  assign db_multi  = !db_zero && !db_single;

  // wait_zero_q blocks acceptance until the buttons have been seen released:
  // it is set on arming (so a button held at arm time is ignored) and after a
  // reject (so one multi-press yields exactly one reject). A single press
  // beats a timeout landing in the same cycle. Output pulses are masked by
  // clear so a reset in the same cycle suppresses them.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    wait_zero_d = wait_zero_q;
    vote_d      = vote_q;
    total_d     = total_q;
    en_n_d      = 1'b0;
    o_vote      = '0;
    o_ready     = 1'b0;
    o_reject    = 1'b0;
    o_timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_arm) begin
          state_d     = ARMED;
          tmo_d       = '0;
          wait_zero_d = 1'b1;
        end
      end
      ARMED: begin
        o_ready = 1'b1;
        tmo_d   = tmo_q + TW'(1);
        if (db_zero) begin
          wait_zero_d = 1'b0;
        end
        if (!wait_zero_q && db_single) begin
          vote_d  = db_vec;
          state_d = CAST;
        end else begin
          if (!wait_zero_q && db_multi) begin
            o_reject    = !clear;
            wait_zero_d = 1'b1;
          end
          if (tmo_q == TW'(ARM_TIMEOUT - 1)) begin
            o_timeout = !clear;
            state_d   = IDLE;
          end
        end
      end
      CAST: begin
        o_vote  = clear ? '0 : vote_q;
        total_d = (total_q == '1) ? total_q : total_q + TOTAL_W'(1);
        state_d = RELEASE;
      end
      RELEASE: begin
        if (db_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      wait_zero_q <= 1'b0;
      vote_q      <= '0;
      total_q     <= '0;
      en_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      wait_zero_q <= wait_zero_d;
      vote_q      <= vote_d;
      total_q     <= total_d;
      en_n_q      <= en_n_d;
    end
  end

  // en_n_q holds the disable for the cycle after clear drops; OR-ing clear in
  // covers the cycles where clear is high but not yet sampled.
  assign o_enable_n = en_n_q | clear;
  assign o_total    = total_q;

endmodule

// File: tb/tb_vote_ballot_ctrl.sv
// tb_vote_ballot_ctrl
// Directed bench for vote_ballot_ctrl with NUM_CAND=4, DEBOUNCE_CYCLES=4 and
// ARM_TIMEOUT=20. Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point, so a press set right after an edge and
// followed by N ticks is observed N cycles later.
module tb_vote_ballot_ctrl;

  logic        clk;
  logic        clear;
  logic        i_arm;
  logic [3:0]  i_btn;
  logic [3:0]  o_vote;
  logic        o_enable_n;
  logic        o_ready;
  logic        o_reject;
  logic        o_timeout;
  logic [15:0] o_total;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_total = '0;

  vote_ballot_ctrl #(
    .NUM_CAND        (4),
    .DEBOUNCE_CYCLES (4),
    .ARM_TIMEOUT     (20)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .i_arm      (i_arm),
    .i_btn      (i_btn),
    .o_vote     (o_vote),
    .o_enable_n (o_enable_n),
    .o_ready    (o_ready),
    .o_reject   (o_reject),
    .o_timeout  (o_timeout),
    .o_total    (o_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
  endtask

  task automatic drain();
    i_btn = 4'b0000;
    i_arm = 1'b0;
    repeat (12) tick();
  endtask

  // Reset with arm and every button active; all must be overridden.
  task automatic test_reset();
    clear = 1'b1; i_arm = 1'b1; i_btn = 4'b1111;
    tick(); tick();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", o_ready); end
    checks++; if (o_vote !== 4'b0000) begin errors++; $display("[TB] FAIL reset_vote: got %b expected 0000", o_vote); end
    checks++; if (o_reject !== 1'b0) begin errors++; $display("[TB] FAIL reset_reject: got %b expected 0", o_reject); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", o_timeout); end
    checks++; if (o_total !== 16'd0) begin errors++; $display("[TB] FAIL reset_total: got %0d expected 0", o_total); end
    checks++; if (o_enable_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_enable_n: got %b expected 1", o_enable_n); end
    clear = 1'b0; i_arm = 1'b0; i_btn = 4'b0000;
    #1;
    checks++; if (o_enable_n !== 1'b1) begin errors++; $display("[TB] FAIL enable_n_after_clear: got %b expected 1", o_enable_n); end
    tick();
    checks++; if (o_enable_n !== 1'b0) begin errors++; $display("[TB] FAIL enable_n_running: got %b expected 0", o_enable_n); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_arm_ignored: got %b expected 0", o_ready); end
    exp_total = '0;
  endtask

  // Clean single press: vote exactly 7 cycles after the press.
  task automatic test_press();
    logic [3:0] exp_vote;
    arm();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL press_ready: got %b expected 1", o_ready); end
    checks++; if (o_enable_n !== 1'b0) begin errors++; $display("[TB] FAIL press_enable_n: got %b expected 0", o_enable_n); end
    i_btn = 4'b0100;
    for (int t = 1; t <= 8; t++) begin
      tick();
      exp_vote = (t == 7) ? 4'b0100 : 4'b0000;
      checks++; if (o_vote !== exp_vote) begin errors++; $display("[TB] FAIL press_vote_t%0d: got %b expected %b", t, o_vote, exp_vote); end
    end
    exp_total = exp_total + 16'd1;
    checks++; if (o_total !== exp_total) begin errors++; $display("[TB] FAIL press_total: got %0d expected %0d", o_total, exp_total); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL press_ready_after: got %b expected 0", o_ready); end
    drain();
  endtask

  // Two buttons held: exactly one reject, no vote, stays armed until timeout.
  task automatic test_reject();
    int rej;
    int rej_at;
    int tmo;
    rej = 0; rej_at = 0; tmo = 0;
    arm();
    i_btn = 4'b0110;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (o_reject === 1'b1) begin rej++; rej_at = t; end
      checks++; if (o_vote !== 4'b0000) begin errors++; $display("[TB] FAIL reject_vote_t%0d: got %b expected 0000", t, o_vote); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reject_ready_t%0d: got %b expected 1", t, o_ready); end
    end
    checks++; if (rej_at != 6) begin errors++; $display("[TB] FAIL reject_cycle: got %0d expected 6", rej_at); end
    i_btn = 4'b0000;
    for (int t = 0; t < 30 && o_ready === 1'b1; t++) begin
      tick();
      if (o_reject === 1'b1) rej++;
      if (o_timeout === 1'b1) tmo++;
    end
    checks++; if (rej != 1) begin errors++; $display("[TB] FAIL reject_count: got %0d expected 1", rej); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL reject_return_idle: got %b expected 0", o_ready); end
    checks++; if (tmo != 1) begin errors++; $display("[TB] FAIL reject_timeout_count: got %0d expected 1", tmo); end
    checks++; if (o_total !== exp_total) begin errors++; $display("[TB] FAIL reject_total: got %0d expected %0d", o_total, exp_total); end
  endtask

  // No press: timeout pulse on the 20th armed cycle, then idle.
  task automatic test_timeout();
    logic exp_tmo;
    arm();
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_c1: got %b expected 0", o_timeout); end
    for (int c = 2; c <= 20; c++) begin
      tick();
      exp_tmo = (c == 20);
      checks++; if (o_timeout !== exp_tmo) begin errors++; $display("[TB] FAIL timeout_c%0d: got %b expected %b", c, o_timeout, exp_tmo); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL timeout_ready_c%0d: got %b expected 1", c, o_ready); end
    end
    tick();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle: got %b expected 0", o_ready); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_single: got %b expected 0", o_timeout); end
    checks++; if (o_total !== exp_total) begin errors++; $display("[TB] FAIL timeout_total: got %0d expected %0d", o_total, exp_total); end
  endtask

  // Bouncing button never settles; only the following stable run votes.
  task automatic test_bounce();
    int votes;
    int vote_at;
    votes = 0; vote_at = 0;
    arm();
    for (int t = 1; t <= 8; t++) begin
      i_btn = (((t - 1) / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (o_vote !== 4'b0000) votes++;
    end
    checks++; if (votes != 0) begin errors++; $display("[TB] FAIL bounce_no_vote: got %0d expected 0", votes); end
    i_btn = 4'b0001;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (o_vote !== 4'b0000) begin
        votes++; vote_at = t;
        checks++; if (o_vote !== 4'b0001) begin errors++; $display("[TB] FAIL bounce_vote_value: got %b expected 0001", o_vote); end
      end
    end
    checks++; if (votes != 1) begin errors++; $display("[TB] FAIL bounce_vote_count: got %0d expected 1", votes); end
    checks++; if (vote_at != 7) begin errors++; $display("[TB] FAIL bounce_vote_cycle: got %0d expected 7", vote_at); end
    exp_total = exp_total + 16'd1;
    checks++; if (o_total !== exp_total) begin errors++; $display("[TB] FAIL bounce_total: got %0d expected %0d", o_total, exp_total); end
    drain();
  endtask

  // Button held through arming is ignored until released; next press casts.
  task automatic test_held_through_arm();
    int votes;
    int vote_at;
    logic [3:0] vote_val;
    votes = 0; vote_at = 0; vote_val = 4'b0000;
    i_btn = 4'b0010;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++; if (o_vote !== 4'b0000) begin errors++; $display("[TB] FAIL held_idle_vote_t%0d: got %b expected 0000", t, o_vote); end
    end
    arm();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL held_ready: got %b expected 1", o_ready); end
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (o_vote !== 4'b0000) votes++;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL held_ready_t%0d: got %b expected 1", t, o_ready); end
    end
    i_btn = 4'b0000;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (o_vote !== 4'b0000) votes++;
    end
    checks++; if (votes != 0) begin errors++; $display("[TB] FAIL held_ignored: got %0d votes expected 0", votes); end
    i_btn = 4'b1000;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (o_vote !== 4'b0000) begin votes++; vote_at = t; vote_val = o_vote; end
    end
    checks++; if (votes != 1) begin errors++; $display("[TB] FAIL held_vote_count: got %0d expected 1", votes); end
    checks++; if (vote_at != 7) begin errors++; $display("[TB] FAIL held_vote_cycle: got %0d expected 7", vote_at); end
    checks++; if (vote_val !== 4'b1000) begin errors++; $display("[TB] FAIL held_vote_value: got %b expected 1000", vote_val); end
    exp_total = exp_total + 16'd1;
    checks++; if (o_total !== exp_total) begin errors++; $display("[TB] FAIL held_total: got %0d expected %0d", o_total, exp_total); end
    drain();
  endtask

  // clear in the CAST cycle suppresses the vote and zeroes the total.
  task automatic test_clear_in_cast();
    arm();
    i_btn = 4'b0001;
    for (int t = 1; t <= 7; t++) tick();
    checks++; if (o_vote !== 4'b0001) begin errors++; $display("[TB] FAIL cast_reached: got %b expected 0001", o_vote); end
    clear = 1'b1;
    #1;
    checks++; if (o_vote !== 4'b0000) begin errors++; $display("[TB] FAIL clear_cast_vote: got %b expected 0000", o_vote); end
    tick();
    clear = 1'b0;
    exp_total = '0;
    checks++; if (o_total !== exp_total) begin errors++; $display("[TB] FAIL clear_cast_total: got %0d expected 0", o_total); end
    checks++; if (o_vote !== 4'b0000) begin errors++; $display("[TB] FAIL clear_cast_vote_after: got %b expected 0000", o_vote); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_cast_ready: got %b expected 0", o_ready); end
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++; if (o_vote !== 4'b0000) begin errors++; $display("[TB] FAIL clear_cast_idle_t%0d: got %b expected 0000", t, o_vote); end
    end
    drain();
  endtask

  // i_arm pulsed while in RELEASE must not re-arm the booth.
  task automatic test_arm_in_release();
    arm();
    i_btn = 4'b0001;
    for (int t = 1; t <= 8; t++) tick();
    exp_total = exp_total + 16'd1;
    i_arm = 1'b1;
    tick();
    i_arm = 1'b0;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_arm_ready: got %b expected 0", o_ready); end
    i_btn = 4'b0000;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_arm_ignored_t%0d: got %b expected 0", t, o_ready); end
    end
    checks++; if (o_total !== exp_total) begin errors++; $display("[TB] FAIL release_total: got %0d expected %0d", o_total, exp_total); end
    arm();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL rearm_after_release: got %b expected 1", o_ready); end
  endtask

  initial begin
    clear = 1'b1;
    i_arm = 1'b0;
    i_btn = 4'b0000;
    test_reset();
    test_press();
    test_reject();
    test_timeout();
    test_bounce();
    test_held_through_arm();
    test_clear_in_cast();
    test_arm_in_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vote_ballot_ctrl.md
VOTE_BALLOT_CTRL -- requirements
Module: vote_ballot_ctrl

Interface
REQ-001 SHALL have parameter NUM_CAND, default 4: number of candidate buttons and vote outputs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: stable-sample cycles required to accept a button state.
REQ-003 SHALL have parameter ARM_TIMEOUT, default 1000: maximum cycles in ARMED without a cast.
REQ-004 SHALL have port clk, input, 1 bit: the only clock, with all logic on its rising edge.
REQ-005 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_arm, input, 1 bit: officer authorises one voter.
REQ-007 SHALL have port i_btn, input, NUM_CAND bits: raw asynchronous candidate buttons, active-high.
REQ-008 SHALL have port o_vote, output, NUM_CAND bits: one-hot single-cycle pulse to candidate counter i_in.
REQ-009 SHALL have port o_enable_n, output, 1 bit: counter enable, active-low (0 = counters enabled).
REQ-010 SHALL have port o_ready, output, 1 bit: high while ARMED.
REQ-011 SHALL have port o_reject, output, 1 bit: single-cycle pulse on a debounced multi-button press.
REQ-012 SHALL have port o_timeout, output, 1 bit: single-cycle pulse when ARM_TIMEOUT expires.
REQ-013 SHALL have port o_total, output, 16 bits: ballots cast since reset.

Function
REQ-014 SHALL pass each i_btn bit through a 2-flop synchroniser before any use.
REQ-015 SHALL accept a synchronised vector as debounced only after it is identical for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-016 SHALL implement the FSM states IDLE, ARMED, CAST and RELEASE.
REQ-017 SHALL move from IDLE to ARMED on i_arm=1, clear the timeout counter and assert o_ready from the next cycle.
REQ-018 SHALL ignore i_arm in every state except IDLE.
REQ-019 In ARMED, a button already held at arm time SHALL be ignored until the debounced vector has been all-zero once.
REQ-020 In ARMED, a debounced vector with exactly one bit set SHALL cause a transition to CAST.
REQ-021 In ARMED, a debounced vector with two or more bits set SHALL pulse o_reject for one cycle, remain in ARMED, and not raise o_reject again until the vector returns to zero.
REQ-022 In CAST, o_vote SHALL equal the accepted one-hot vector for exactly one cycle, o_total SHALL increment (saturating at 16'hFFFF), and the FSM SHALL move to RELEASE.
REQ-023 In RELEASE, the FSM SHALL wait for the debounced vector to be all-zero, then go to IDLE.
REQ-024 When the ARMED dwell reaches ARM_TIMEOUT cycles without entering CAST, o_timeout SHALL pulse for one cycle and the FSM SHALL go to IDLE.
REQ-025 If a single-bit acceptance and the timeout occur in the same cycle, the cast SHALL win.
REQ-026 Latency: o_vote SHALL assert exactly 2 + DEBOUNCE_CYCLES + 1 cycles after a clean press first appears at i_btn.
REQ-027 o_enable_n SHALL be 0 in every state; it SHALL be 1 only during clear and in the cycle after clear deasserts.
REQ-028 o_vote SHALL be all-zero in every state except CAST.

Reset
REQ-029 With clear=1 at a rising edge, the block SHALL go to IDLE with o_vote=0, o_ready=0, o_reject=0, o_timeout=0, o_total=0, o_enable_n=1, and synchronisers and debounce counters zeroed.
REQ-030 clear SHALL override i_arm and every button event in the same cycle.
REQ-031 clear asserted during CAST SHALL suppress o_vote and leave o_total at 0.

Structure
REQ-032 Package ballot_pkg SHALL hold the FSM state typedef, the default parameter values and the o_total width constant.
REQ-033 Sub-module ballot_debounce SHALL implement the synchroniser plus stability counter for the NUM_CAND-bit vector, and SHALL be instantiated once.

Verification (NUM_CAND=4, DEBOUNCE_CYCLES=4, ARM_TIMEOUT=20)
REQ-034 Arm, then hold i_btn=4'b0100 clean -> o_vote=4'b0100 for 1 cycle exactly 7 cycles after the press, and o_total=1.
REQ-035 Arm, then i_btn=4'b0110 held 10 cycles -> one o_reject pulse, no o_vote, and o_ready remains 1.
REQ-036 Arm with no press -> o_timeout pulses on the 20th ARMED cycle, the FSM returns to IDLE, and o_total is unchanged.
REQ-037 i_btn toggling 4'b0001/4'b0000 every 2 cycles, then stable 4'b0001 -> exactly one o_vote, after the stable run only.
REQ-038 Button held through arm, then released and pressed 4'b1000 -> first hold ignored, and the second press casts o_vote=4'b1000.
REQ-039 clear=1 in the CAST cycle, and i_arm pulsed while in RELEASE -> no o_vote, o_total=0, and the i_arm pulse is ignored.
